// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: entry layout and capture FSM encoding.
package uart_pkg;

    // Flag offsets are relative to the bit just above the data field.
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_FERR     = 0;
    localparam int ENT_PERR     = 1;
    localparam int ENT_OVF      = 2;
    localparam int ENT_FLAG_W   = 3;

    function automatic int ent_w(input int data_w);
        return data_w + ENT_FLAG_W;
    endfunction

    typedef enum logic {
        RXF_IDLE = 1'b0,
        RXF_WAIT = 1'b1
    } rxf_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x (DATA_W+3) register file for receive entries.
// One synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int ENT_W = ent_w(DATA_W),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [ENT_W-1:0] wr_entry,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [ENT_W-1:0] rd_entry
);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_entry;
        end
    end

    // Storage is not reset; the top gates reads with empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receive engine: captures frames into a FWFT FIFO.
// Define UART_RX_FIFO_ERR_DROP_EN to ack-and-discard frames with framing/parity errors.
//
// state    | meaning
// RXF_IDLE | waiting for eng_rdy; acks and captures a frame when room (or dropping)
// RXF_WAIT | frame acked; waiting for eng_rdy to fall so one frame is captured once
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eng_rdy,
    input  logic [DATA_W-1:0] eng_data,
    input  logic              eng_ferr,
    input  logic              eng_perr,
    input  logic              eng_ovf,
    output logic              eng_read,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_ferr,
    output logic              rd_perr,
    output logic              rd_ovf,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ent_w(DATA_W);

    rxf_state_e       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_w, empty_w;
    logic             ack, wr_en, pop;
    logic [ENT_W-1:0] wr_entry, rd_entry;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign pop     = rd_req && !empty_w;

`ifdef UART_RX_FIFO_ERR_DROP_EN
    logic frame_err;
    assign frame_err = eng_ferr | eng_perr;
`endif

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            RXF_IDLE: begin
`ifdef UART_RX_FIFO_ERR_DROP_EN
                // Errored frames need no room, so they are acked even when full.
                if (eng_rdy && (frame_err || !full_w)) begin
                    ack     = 1'b1;
                    wr_en   = !frame_err;
                    state_d = RXF_WAIT;
                end
`else
                if (eng_rdy && !full_w) begin
                    ack     = 1'b1;
                    wr_en   = 1'b1;
                    state_d = RXF_WAIT;
                end
`endif
            end
            RXF_WAIT: begin
                if (!eng_rdy) begin
                    state_d = RXF_IDLE;
                end
            end
            default: state_d = RXF_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RXF_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry = {eng_ovf, eng_perr, eng_ferr, eng_data};

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr_q),
        .wr_entry (wr_entry),
        .rd_addr  (rd_ptr_q),
        .rd_entry (rd_entry)
    );

    assign eng_read = ack;
    assign rd_data  = empty_w ? '0 : rd_entry[ENT_DATA_LSB +: DATA_W];
    assign rd_ferr  = !empty_w && rd_entry[DATA_W + ENT_FERR];
    assign rd_perr  = !empty_w && rd_entry[DATA_W + ENT_PERR];
    assign rd_ovf   = !empty_w && rd_entry[DATA_W + ENT_OVF];
    assign empty    = empty_w;
    assign full     = full_w;
    assign count    = count_q;

endmodule
